// File: rtl/iq_uart_streamer.sv
// ---------------------------------------------------------------------------
// iq_uart_streamer
// Packs decimated I/Q sample pairs into 5-byte frames
//   {SYNC_BYTE, SEQ, I, Q, CHK = SEQ+I+Q mod 256}
// and hands them one byte at a time to uart_tx through its DV/Active/Done
// handshake. Incoming pairs are buffered in a small FIFO so that bursts of
// samples can be absorbed while the serial link is busy.
//
// Ports
//   osc_clk       in   system clock, all logic on rising edge
//   reset_n       in   synchronous active-low reset
//   i_enable      in   1 = accept new samples into the FIFO
//   i_smp_valid   in   one-cycle strobe, i_I/i_Q valid
//   i_I, i_Q      in   8-bit two's complement samples
//   o_Tx_DV       out  one-cycle pulse, o_Tx_Byte valid for uart_tx
//   o_Tx_Byte     out  byte to transmit, held until the next DV
//   i_Tx_Active   in   uart_tx busy shifting a byte
//   i_Tx_Done     in   uart_tx one-cycle byte-finished pulse
//   o_overflow    out  sticky, a sample was dropped on a full FIFO
//   o_fifo_level  out  number of pairs currently stored
//   o_busy        out  1 whenever the frame FSM is not idle
// ---------------------------------------------------------------------------
module iq_uart_streamer #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                          osc_clk,
    input  logic                          reset_n,
    input  logic                          i_enable,
    input  logic                          i_smp_valid,
    input  logic [7:0]                    i_I,
    input  logic [7:0]                    i_Q,
    output logic                          o_Tx_DV,
    output logic [7:0]                    o_Tx_Byte,
    input  logic                          i_Tx_Active,
    input  logic                          i_Tx_Done,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_busy
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned PAIR_W = 16;
    localparam int unsigned IDX_W  = 3;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_SEND      = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;
    localparam logic [1:0] S_GAP       = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(4);

    // -----------------------------------------------------------------------
    // Sample-pair FIFO
    // -----------------------------------------------------------------------
    logic [PAIR_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [PAIR_W-1:0] rd_data;
    logic              full;
    logic              push;
    logic              pop;
    logic              drop;
    logic              overflow;

    // FSM registers
    logic [1:0]        state;
    logic [1:0]        state_n;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_n;
    logic [7:0]        seq;
    logic [7:0]        seq_n;
    logic [7:0]        frm_i;
    logic [7:0]        frm_i_n;
    logic [7:0]        frm_q;
    logic [7:0]        frm_q_n;
    logic [7:0]        frm_chk;
    logic [7:0]        frm_chk_n;
    logic              tx_dv;
    logic              tx_dv_n;
    logic [7:0]        tx_byte;
    logic [7:0]        tx_byte_n;
    logic              busy;
    logic              busy_n;
    logic [7:0]        cur_byte;

    assign full    = (level == LVL_W'(FIFO_DEPTH));
    assign rd_data = mem[rd_ptr];

    // A pair is taken only from IDLE while uart_tx is quiet
    assign pop  = (state == S_IDLE) && (level != '0) && !i_Tx_Active;

    // A concurrent pop frees a slot, so a full FIFO can still accept
    assign push = i_smp_valid && i_enable && (!full || pop);
    assign drop = i_smp_valid && i_enable && full && !pop;

    // Storage array, no reset needed: pointers/level define validity
    always_ff @(posedge osc_clk) begin
        if (push) begin
            mem[wr_ptr] <= {i_I, i_Q};
        end
    end

    // Pointers, occupancy and sticky overflow flag
    always_ff @(posedge osc_clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level + LVL_W'(push) - LVL_W'(pop);
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Frame byte selection
    // -----------------------------------------------------------------------
    always_comb begin
        cur_byte = SYNC_BYTE;
        case (idx)
            3'd0:    cur_byte = SYNC_BYTE;
            3'd1:    cur_byte = seq;
            3'd2:    cur_byte = frm_i;
            3'd3:    cur_byte = frm_q;
            default: cur_byte = frm_chk;
        endcase
    end

    // -----------------------------------------------------------------------
    // Frame FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge osc_clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            idx     <= '0;
            seq     <= '0;
            frm_i   <= '0;
            frm_q   <= '0;
            frm_chk <= '0;
            tx_dv   <= 1'b0;
            tx_byte <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            seq     <= seq_n;
            frm_i   <= frm_i_n;
            frm_q   <= frm_q_n;
            frm_chk <= frm_chk_n;
            tx_dv   <= tx_dv_n;
            tx_byte <= tx_byte_n;
            busy    <= busy_n;
        end
    end

    // Frame FSM: next state and registered-output values
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        seq_n     = seq;
        frm_i_n   = frm_i;
        frm_q_n   = frm_q;
        frm_chk_n = frm_chk;
        tx_dv_n   = 1'b0;
        tx_byte_n = tx_byte;

        case (state)
            S_IDLE: begin
                if (pop) begin
                    frm_i_n   = rd_data[15:8];
                    frm_q_n   = rd_data[7:0];
                    frm_chk_n = 8'(seq + rd_data[15:8] + rd_data[7:0]);
                    idx_n     = '0;
                    state_n   = S_SEND;
                end
            end
            S_SEND: begin
                tx_dv_n   = 1'b1;
                tx_byte_n = cur_byte;
                state_n   = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (i_Tx_Done) begin
                    if (idx == LAST_IDX) begin
                        seq_n   = seq + 8'd1;
                        state_n = S_IDLE;
                    end else begin
                        idx_n   = idx + IDX_W'(1);
                        state_n = S_GAP;
                    end
                end
            end
            S_GAP: begin
                // Never raise DV while uart_tx is still shifting
                if (!i_Tx_Active) begin
                    state_n = S_SEND;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        busy_n = (state_n != S_IDLE);
    end

    assign o_Tx_DV      = tx_dv;
    assign o_Tx_Byte    = tx_byte;
    assign o_overflow   = overflow;
    assign o_fifo_level = level;
    assign o_busy       = busy;

endmodule

// File: tb/tb_iq_uart_streamer.sv
// ---------------------------------------------------------------------------
// tb_iq_uart_streamer
// Directed bench for iq_uart_streamer. A small uart_tx model answers every
// DV with Active/Done after a programmable latency and records the bytes;
// a scoreboard of expected pairs plus a running SEQ rebuilds each frame.
// ---------------------------------------------------------------------------
module tb_iq_uart_streamer;

    localparam int unsigned FIFO_DEPTH = 8;
    localparam logic [7:0]  SYNC       = 8'hA5;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       smp_valid;
    logic [7:0] s_i;
    logic [7:0] s_q;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_active;
    logic       tx_done;
    logic       overflow;
    logic [3:0] level;
    logic       busy;

    logic       m_active;
    logic       m_done;
    logic       man_active;
    logic       man_done;

    assign tx_active = m_active | man_active;
    assign tx_done   = m_done | man_done;

    int         n_assert;
    int         n_fail;
    int         dv_count;
    int         lat;
    int         base;
    logic [7:0] exp_seq;
    logic [7:0] cap_q [$];
    logic [15:0] exp_q [$];

    iq_uart_streamer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .SYNC_BYTE  (SYNC)
    ) dut (
        .osc_clk      (clk),
        .reset_n      (reset_n),
        .i_enable     (enable),
        .i_smp_valid  (smp_valid),
        .i_I          (s_i),
        .i_Q          (s_q),
        .o_Tx_DV      (tx_dv),
        .o_Tx_Byte    (tx_byte),
        .i_Tx_Active  (tx_active),
        .i_Tx_Done    (tx_done),
        .o_overflow   (overflow),
        .o_fifo_level (level),
        .o_busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // uart_tx model: capture byte on DV, stay Active, pulse Done after lat cycles
    initial begin
        m_active = 1'b0;
        m_done   = 1'b0;
        dv_count = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_dv === 1'b1) begin
                dv_count++;
                cap_q.push_back(tx_byte);
                m_active = 1'b1;
                repeat (lat - 1) begin
                    @(posedge clk);
                    #1;
                end
                m_done = 1'b1;
                @(posedge clk);
                #1;
                m_done   = 1'b0;
                m_active = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [7:0] i, input logic [7:0] q, input bit accept);
        @(negedge clk);
        smp_valid = 1'b1;
        s_i       = i;
        s_q       = q;
        if (accept) exp_q.push_back({i, q});
        @(negedge clk);
        smp_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_dv",       40'(tx_dv),    40'(0));
        chk("rst_byte",     40'(tx_byte),  40'(0));
        chk("rst_overflow", 40'(overflow), 40'(0));
        chk("rst_level",    40'(level),    40'(0));
        chk("rst_busy",     40'(busy),     40'(0));
        reset_n = 1'b1;
        exp_seq = 8'd0;
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_frames(input string tag, input int n, input int budget);
        int cyc;
        cyc = 0;
        while (!(cap_q.size() >= 5 * n && !busy && !tx_active) && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk(tag, 40'(cap_q.size()), 40'(5 * n));
    endtask

    task automatic check_frames(input string tag, input int n);
        logic [15:0] p;
        logic [39:0] obs;
        logic [39:0] expv;
        for (int f = 0; f < n; f++) begin
            p = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0;
            obs = '0;
            for (int b = 0; b < 5; b++) begin
                obs = {obs[31:0], (cap_q.size() > 0) ? cap_q.pop_front() : 8'h00};
            end
            expv = {SYNC, exp_seq, p, 8'(exp_seq + p[15:8] + p[7:0])};
            chk(tag, obs, expv);
            exp_seq = exp_seq + 8'd1;
        end
    endtask

    initial begin
        int cyc;
        n_assert   = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        enable     = 1'b1;
        smp_valid  = 1'b0;
        s_i        = '0;
        s_q        = '0;
        man_active = 1'b0;
        man_done   = 1'b0;
        lat        = 130;
        exp_seq    = 8'd0;

        // 1: single frame, latency and byte order
        do_reset();
        push(8'h12, 8'h34, 1'b1);
        chk("t1_level_after_write", 40'(level), 40'(1));
        chk("t1_dv_write_cycle",    40'(tx_dv), 40'(0));
        @(negedge clk);
        chk("t1_level_after_pop",   40'(level), 40'(0));
        chk("t1_busy_after_pop",    40'(busy),  40'(1));
        chk("t1_dv_pop_cycle",      40'(tx_dv), 40'(0));
        @(negedge clk);
        chk("t1_dv_two_cycles",     40'(tx_dv),   40'(1));
        chk("t1_first_byte",        40'(tx_byte), 40'(8'hA5));
        wait_frames("t1_frame_bytes", 1, 2000);
        check_frames("t1_frame", 1);
        repeat (20) @(negedge clk);
        chk("t1_dv_pulses",         40'(dv_count), 40'(5));
        chk("t1_byte_held",         40'(tx_byte),  40'(8'h46));

        // 2: 300-pair stream with SEQ wrap
        lat = 4;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            push(8'(k), 8'(k * 3 + 7), 1'b1);
            repeat (33) @(negedge clk);
        end
        wait_frames("t2_stream_bytes", 300, 2000);
        check_frames("t2_stream_frame", 300);
        chk("t2_no_overflow", 40'(overflow), 40'(0));
        chk("t2_seq_wrapped", 40'(exp_seq),  40'(8'h2C));

        // 5: Active holds off DV in IDLE and in GAP
        base = dv_count;
        man_active = 1'b1;
        push(8'h7F, 8'h80, 1'b1);
        repeat (20) @(negedge clk);
        chk("t5_idle_no_dv", 40'(dv_count), 40'(base));
        chk("t5_idle_busy",  40'(busy),     40'(0));
        chk("t5_idle_level", 40'(level),    40'(1));
        man_active = 1'b0;
        @(negedge clk);
        chk("t5_idle_pop_no_dv", 40'(tx_dv), 40'(0));
        @(negedge clk);
        chk("t5_idle_dv",        40'(tx_dv),   40'(1));
        chk("t5_idle_sync",      40'(tx_byte), 40'(SYNC));
        man_active = 1'b1;
        repeat (24) @(negedge clk);
        chk("t5_gap_no_dv",  40'(dv_count), 40'(base + 1));
        chk("t5_gap_busy",   40'(busy),     40'(1));
        man_active = 1'b0;
        @(negedge clk);
        chk("t5_gap_send_no_dv", 40'(tx_dv), 40'(0));
        @(negedge clk);
        chk("t5_gap_dv",         40'(tx_dv),   40'(1));
        chk("t5_gap_seq_byte",   40'(tx_byte), 40'(exp_seq));
        wait_frames("t5_frame_bytes", 1, 500);
        check_frames("t5_frame", 1);

        // 3: overflow while uart_tx busy, then ordered drain
        base = dv_count;
        man_active = 1'b1;
        for (int k = 0; k < 8; k++) begin
            push(8'(8'h10 + k), 8'(8'hF0 - k), 1'b1);
        end
        chk("t3_level_full_no_ovf", 40'(overflow), 40'(0));
        push(8'hEE, 8'hDD, 1'b0);
        chk("t3_level_full", 40'(level),    40'(8));
        chk("t3_overflow",   40'(overflow), 40'(1));
        @(negedge clk);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        @(negedge clk);
        chk("t3_spurious_done_busy", 40'(busy),     40'(0));
        chk("t3_spurious_done_dv",   40'(dv_count), 40'(base));
        man_active = 1'b0;
        wait_frames("t3_drain_bytes", 8, 1000);
        check_frames("t3_drain_frame", 8);
        chk("t3_overflow_sticky", 40'(overflow), 40'(1));
        chk("t3_level_empty",     40'(level),    40'(0));

        // 4: push on the pop cycle of a full FIFO
        do_reset();
        man_active = 1'b1;
        for (int k = 0; k < 8; k++) begin
            push(8'(8'h40 + k), 8'(8'h20 + 2 * k), 1'b1);
        end
        chk("t4_level_full", 40'(level), 40'(8));
        @(negedge clk);
        man_active = 1'b0;
        smp_valid  = 1'b1;
        s_i        = 8'hC3;
        s_q        = 8'h3C;
        exp_q.push_back(16'hC33C);
        @(negedge clk);
        smp_valid = 1'b0;
        chk("t4_level_held", 40'(level),    40'(8));
        chk("t4_no_overflow", 40'(overflow), 40'(0));
        chk("t4_busy",        40'(busy),     40'(1));
        wait_frames("t4_drain_bytes", 9, 1000);
        check_frames("t4_drain_frame", 9);
        chk("t4_no_overflow_end", 40'(overflow), 40'(0));

        // 6: reset during the Q byte aborts the frame, SEQ restarts
        lat = 130;
        push(8'h55, 8'hAA, 1'b1);
        cyc = 0;
        while (cap_q.size() < 4 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        chk("t6_reach_q_byte", 40'(cap_q.size()), 40'(4));
        chk("t6_q_byte",       40'(tx_byte),      40'(8'hAA));
        do_reset();
        base = dv_count;
        repeat (150) @(negedge clk);
        chk("t6_no_dv_after_reset", 40'(dv_count), 40'(base));
        chk("t6_idle_after_reset",  40'(busy),     40'(0));
        lat = 4;
        cap_q.delete();
        push(8'h01, 8'h02, 1'b1);
        wait_frames("t6_frame_bytes", 1, 500);
        check_frames("t6_frame_seq0", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
